// File: rtl/count_match_capture.sv
// Watches an upstream 8-bit counter for compare-match and FF->00 wrap events.
// Detected events are timestamped with a wrap epoch and queued in a small FIFO.
module count_match_capture #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] count_in,
    input  logic       cmp_wr,
    input  logic [7:0] cmp_data,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_type,
    output logic [7:0] evt_count,
    output logic [7:0] evt_epoch,
    output logic [3:0] fifo_level,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry layout: {wrap, match, count[7:0], epoch[7:0]}
    typedef logic [17:0] entry_t;

    logic [7:0]    prev_count_q, prev_count_d;
    logic [7:0]    cmp_q, cmp_d;
    logic [7:0]    epoch_q, epoch_d;
    logic          armed_q, armed_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    level_q, level_d;
    logic          overflow_q, overflow_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];

    logic match, wrap, evt, pop, full, push, drop;
    entry_t head;

    always_comb begin
        prev_count_d = count_in;
        cmp_d        = cmp_wr ? cmp_data : cmp_q;
        // The first edge after reset only primes prev_count; no detection yet.
        armed_d      = 1'b1;

        match = armed_q && (count_in == cmp_q) && (prev_count_q != cmp_q);
        wrap  = armed_q && (prev_count_q == 8'hFF) && (count_in == 8'h00);
        evt   = match || wrap;

        epoch_d = wrap ? epoch_q + 8'd1 : epoch_q;

        pop  = (level_q != 4'd0) && evt_ready;
        full = (level_q == 4'(DEPTH));
        push = evt && (!full || pop);
        drop = evt && full && !pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {wrap, match, count_in, epoch_d};
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear wins, so no loss goes unreported.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_count_q <= 8'h00;
            cmp_q        <= 8'h80;
            epoch_q      <= 8'h00;
            armed_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= 4'd0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            prev_count_q <= prev_count_d;
            cmp_q        <= cmp_d;
            epoch_q      <= epoch_d;
            armed_q      <= armed_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            mem_q        <= mem_d;
        end
    end

    // Head fields read as zero whenever the FIFO is empty.
    assign head       = mem_q[rd_ptr_q];
    assign evt_valid  = (level_q != 4'd0);
    assign evt_type   = evt_valid ? head[17:16] : 2'b00;
    assign evt_count  = evt_valid ? head[15:8]  : 8'h00;
    assign evt_epoch  = evt_valid ? head[7:0]   : 8'h00;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/count_match_capture.md
COUNT_MATCH_CAPTURE -- requirements
Module: count_match_capture

Interface
REQ-001 Parameter: DEPTH, default 4, event FIFO entries; power of two, 2..8.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 count_in  input  8  current value of the upstream 8-bit counter, sampled every cycle.
REQ-005 cmp_wr  input  1  write strobe for compare register.
REQ-006 cmp_data  input  8  compare value written when cmp_wr=1.
REQ-007 evt_ready  input  1  consumer accepts head event this cycle.
REQ-008 evt_valid  output  1  FIFO non-empty; head event presented.
REQ-009 evt_type  output  2  head event type: bit0=match, bit1=wrap.
REQ-010 evt_count  output  8  count_in value captured with the head event.
REQ-011 evt_epoch  output  8  wrap epoch captured with the head event.
REQ-012 fifo_level  output  4  number of stored events, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: event dropped because FIFO full.
REQ-014 ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-015 prev_count SHALL register count_in every cycle; edge detection compares count_in against prev_count.
REQ-016 Match event SHALL fire when count_in==cmp_reg and prev_count!=cmp_reg (entry into equality only; a held value fires once).
REQ-017 Wrap event SHALL fire when prev_count==8'hFF and count_in==8'h00.
REQ-018 Any other transition (load jumps, holds, decrements) SHALL produce no wrap event; a load landing on cmp_reg SHALL produce a match.
REQ-019 Match and wrap in the same cycle SHALL push one entry with evt_type=2'b11.
REQ-020 cmp_wr SHALL update cmp_reg at the clock edge; detection in the write cycle uses the old cmp_reg.
REQ-021 epoch SHALL be an 8-bit counter incremented on each wrap event, rolling 8'hFF->8'h00.
REQ-022 Captured epoch SHALL be the post-increment value (a wrap event stores its own new epoch).
REQ-023 Captured evt_count SHALL equal count_in in the detection cycle.
REQ-024 Push latency: event detected in cycle N SHALL be written at the end of cycle N; evt_valid high in cycle N+1 if FIFO was empty; no combinational bypass.
REQ-025 Pop SHALL occur when evt_valid and evt_ready are both 1; head advances at that edge.
REQ-026 evt_type/evt_count/evt_epoch SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-027 FIFO SHALL be first-in first-out with wrap-around read/write pointers.
REQ-028 Push while full and no pop SHALL drop the new event, leave contents unchanged, and set overflow.
REQ-029 Push and pop in the same cycle while full SHALL accept the push; fifo_level unchanged; no overflow.
REQ-030 Push and pop in the same cycle while level 1..DEPTH-1 SHALL keep fifo_level unchanged.
REQ-031 evt_ready while empty SHALL have no effect.
REQ-032 ovf_clr SHALL clear overflow; a drop in the same cycle SHALL take priority (overflow stays 1).
REQ-033 fifo_level SHALL be registered and exact every cycle.

Reset
REQ-034 reset=1 SHALL immediately force: prev_count=0, cmp_reg=8'h80, epoch=0, FIFO empty, evt_valid=0, fifo_level=0, overflow=0; evt_type/evt_count/evt_epoch=0.
REQ-035 Reset mid-operation SHALL discard all stored events; no event fires in the cycle reset deasserts.
REQ-036 With prev_count=0 after reset, count_in=0 with cmp_reg=0 SHALL not fire a match until count_in leaves and re-enters 0.

Verification
REQ-037 cmp_data=8'h05 written, count_in 0..7 incrementing, evt_ready=1 -> one event type 2'b01, count 8'h05, epoch 0, valid one cycle after count_in=5.
REQ-038 count_in 8'hFE,8'hFF,8'h00 with cmp_reg=8'h00 -> one entry type 2'b11, count 8'h00, epoch 1.
REQ-039 evt_ready=0, DEPTH+1 wraps -> fifo_level=4, overflow=1, first four epochs 1..4 stored; then ovf_clr -> overflow=0.
REQ-040 FIFO full, push and pop same cycle -> level stays 4, overflow stays 0, new event appears last.
REQ-041 count_in held at cmp_reg for 10 cycles -> exactly one match; load jump 8'h10->8'h00 -> no wrap event.
REQ-042 reset asserted with 3 events stored -> evt_valid=0, fifo_level=0 immediately, epoch=0, cmp_reg=8'h80.
